// File: rtl/accum_lane_scheduler.sv
// Four-lane round-robin scheduler sharing one accumulate adder, with a one-entry result register.
// Optional macro ACCUM_SAT_EN: clamp row sums to all-ones on carry-out instead of wrapping.
module accum_lane_scheduler #(
    parameter int DATA_W = 24,
    parameter int CNT_W  = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [3:0]                req,
    input  logic [4*(DATA_W+1)-1:0]   req_data,
    output logic [3:0]                gnt,
    input  logic                      flush,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [DATA_W-1:0]         res_data,
    output logic [1:0]                res_lane,
    output logic [CNT_W-1:0]          res_count,
    output logic                      res_ovf,
    output logic                      busy
);
    localparam int LANES = 4;

    logic [DATA_W-1:0] psum [LANES];
    logic [CNT_W-1:0]  cnt  [LANES];
    logic [LANES-1:0]  ovf;
    logic [1:0]        ptr;

    logic [DATA_W:0]   words [LANES];
    logic [LANES-1:0]  last;
    logic [LANES-1:0]  elig;
    logic [1:0]        sel;
    logic              grant_any;

    logic [DATA_W-1:0] payload;
    logic [DATA_W-1:0] raw_sum;
    logic [DATA_W-1:0] sum;
    logic              carry;
    logic              last_sel;
    logic              empty_sel;
    logic              ovf_next;
    logic [CNT_W-1:0]  cnt_next;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            words[i] = req_data[i*(DATA_W+1) +: DATA_W+1];
            last[i]  = words[i][DATA_W];
        end
    end

    // A pending result only blocks row closes; partial words always flow.
    assign elig = req & (~last | {LANES{~res_valid | res_ready}});

    always_comb begin
        grant_any = 1'b0;
        sel       = '0;
        for (int j = 0; j < LANES; j++) begin
            if (!grant_any && elig[ptr + 2'(j)]) begin
                grant_any = 1'b1;
                sel       = ptr + 2'(j);
            end
        end
        if (flush || !reset) begin
            grant_any = 1'b0;
        end
        gnt = grant_any ? (4'b0001 << sel) : 4'b0000;
    end

    always_comb begin
        payload            = words[sel][DATA_W-1:0];
        last_sel           = words[sel][DATA_W];
        empty_sel          = last_sel && (payload == '0);
        {carry, raw_sum}   = {1'b0, psum[sel]} + {1'b0, payload};
        ovf_next           = ovf[sel] | carry;
`ifdef ACCUM_SAT_EN
        sum = ovf_next ? '1 : raw_sum;
`else
        sum = raw_sum;
`endif
        if (empty_sel || (cnt[sel] == '1)) begin
            cnt_next = cnt[sel];
        end else begin
            cnt_next = cnt[sel] + CNT_W'(1);
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            busy = busy | (cnt[i] != '0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) begin
                psum[i] <= '0;
                cnt[i]  <= '0;
            end
            ovf       <= '0;
            ptr       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_lane  <= '0;
            res_count <= '0;
            res_ovf   <= 1'b0;
        end else begin
            if (flush) begin
                for (int i = 0; i < LANES; i++) begin
                    psum[i] <= '0;
                    cnt[i]  <= '0;
                end
                ovf <= '0;
            end else if (grant_any) begin
                if (last_sel) begin
                    psum[sel] <= '0;
                    cnt[sel]  <= '0;
                    ovf[sel]  <= 1'b0;
                end else begin
                    psum[sel] <= sum;
                    cnt[sel]  <= cnt_next;
                    ovf[sel]  <= ovf_next;
                end
            end

            if (grant_any) begin
                ptr <= sel + 2'd1;
            end

            // A new close wins over an accept in the same cycle.
            if (grant_any && last_sel) begin
                res_valid <= 1'b1;
                res_data  <= sum;
                res_lane  <= sel;
                res_count <= cnt_next;
                res_ovf   <= ovf_next;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/accum_lane_scheduler.md
Name: accum_lane_scheduler

Overview:
- Shares one 24-bit accumulate adder between four row lanes of the sparse-product accumulation path.
- Each lane streams 25-bit words: bit 24 is the end-of-row flag, bits 23:0 are the product payload.
- A round-robin arbiter grants one lane per cycle and keeps a partial sum and element count per lane.
- When a row closes, the block emits {sum, lane, count, overflow} through a one-entry valid/ready result register.

Parameters:
- DATA_W, 24, payload and sum width; the word width is DATA_W+1.
- CNT_W, 4, per-lane element counter width; the counter saturates at all-ones.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all state.
- req  in  4  per-lane request; a lane holds req and its word until granted.
- req_data  in  4*(DATA_W+1)  lane i word at bits [i*(DATA_W+1) +: DATA_W+1].
- gnt  out  4  combinational one-hot grant; req[i]&gnt[i] is the transfer.
- flush  in  1  synchronous clear of all lane partial state.
- res_valid  out  1  result register holds a closed row.
- res_ready  in  1  consumer accepts the result.
- res_data  out  DATA_W  row sum.
- res_lane  out  2  lane index of the row.
- res_count  out  CNT_W  number of elements summed.
- res_ovf  out  1  the row wrapped or saturated.
- busy  out  1  OR of all lane counts being nonzero.

Behaviour:
- Reset (reset=0, asynchronous): psum[0..3]=0, cnt[0..3]=0, ovf[0..3]=0, ptr=0, res_valid=0, res_data=0, res_lane=0, res_count=0, res_ovf=0. gnt=0 while reset is asserted.
- Eligibility:
  - elig[i] = req[i] && (!last[i] || !res_valid || res_ready).
  - Non-last words are always eligible, so backpressure only blocks row closes.
- Arbitration:
  - Search starts at ptr: ptr, ptr+1, … mod 4. The first eligible lane k is granted.
  - On a grant, ptr <= k+1 mod 4. With no grant, ptr holds.
- Grant to lane k, single-cycle, in the same edge: sum = psum[k] + payload; c = cnt[k] + 1, saturating; o = ovf[k] | carry-out.
  - Non-last word: psum[k] <= sum, cnt[k] <= c, ovf[k] <= o.
  - Last word: res_data <= sum, res_lane <= k, res_count <= c, res_ovf <= o, res_valid <= 1. The lane clears: psum, cnt and ovf go to 0.
  - Empty terminator (word == 1<<DATA_W): closes the row with res_data = psum[k], res_count = cnt[k], no increment.
- A back-to-back grant to the same lane has no hazard, because the update completes in one cycle.
- Result register:
  - res_valid && res_ready with no new close: res_valid <= 0.
  - Simultaneous accept and new close: load the new result, res_valid stays 1.
  - Result fields are stable while res_valid && !res_ready.
- flush:
  - Highest priority over grants: gnt=0 that cycle.
  - All psum, cnt and ovf clear; ptr and the result register are unaffected.
- Reset mid-row: the partial row is discarded and is never emitted.
- res_count saturates at 2^CNT_W-1; the sum keeps accumulating.

Optional Feature:
- Macro ACCUM_SAT_EN.
- Defined: on carry-out the sum clamps to all-ones (unsigned) and remains clamped for the rest of the row; res_ovf=1.
- Undefined: the sum wraps modulo 2^DATA_W; res_ovf=1 records the wrap.

Test Plan:
- Lane 0 only, words 3, 5, then last|7 → three consecutive gnt[0]; one cycle after the third grant res_valid=1, res_data=15, res_lane=0, res_count=3, res_ovf=0.
- All four lanes request non-last words continuously from reset → gnt sequence 1,2,4,8,1,2… (one-hot); busy=1 after the first grant.
- res_valid=1 held with res_ready=0; lane 1 presents a last word and lane 2 a non-last word → gnt[1]=0 and lane 2 granted. Raise res_ready → gnt[1] in the same cycle, and the new result replaces the old one.
- Lane 2 words 0xFFFFFF, then last|0x000002 → res_data=0x000001, res_ovf=1. With ACCUM_SAT_EN defined → res_data=0xFFFFFF, res_ovf=1.
- Lane 3 empty terminator 0x1000000 with no prior words → res_data=0, res_count=0, res_lane=3.
- Lane 0 sends 10, then flush, then last|4 → res_data=4, res_count=1. Separately, reset pulsed low mid-row → all outputs 0 and no result emitted for the aborted row.
